// File: rtl/fft_bar_ram_writer_if.sv
// Stream input, bar-RAM Avalon-MM master port and frame status of the bar RAM writer.
// The writer is the master; the bench or surrounding fabric connects through the slave view.
interface fft_bar_ram_writer_if;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        in_sop;
  logic        in_eop;
  logic [9:0]  ram_address;
  logic [3:0]  ram_byteenable;
  logic        ram_chipselect;
  logic        ram_write;
  logic [31:0] ram_writedata;
  logic [31:0] ram_readdata;
  logic        ram_clken;
  logic        bank_sel;
  logic        frame_done;
  logic [15:0] frame_count;
  logic        frame_err;

  modport master (
    input  in_valid, in_data, in_sop, in_eop, ram_readdata,
    output in_ready, ram_address, ram_byteenable, ram_chipselect, ram_write,
           ram_writedata, ram_clken, bank_sel, frame_done, frame_count, frame_err
  );

  modport slave (
    output in_valid, in_data, in_sop, in_eop, ram_readdata,
    input  in_ready, ram_address, ram_byteenable, ram_chipselect, ram_write,
           ram_writedata, ram_clken, bank_sel, frame_done, frame_count, frame_err
  );
endinterface

// File: rtl/fft_bar_ram_writer.sv
// Turns a stream of FFT magnitudes into peak-hold bar heights, reading the front bank
// and writing the back bank of a ping-pong bar RAM, swapping banks on each full frame.
module fft_bar_ram_writer #(
  parameter int NUM_BINS   = 512,
  parameter int MAG_SHIFT  = 4,
  parameter int MAX_HEIGHT = 479,
  parameter int DECAY      = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  fft_bar_ram_writer_if.master bus
);

  localparam logic [9:0] LAST_IDX = 10'(NUM_BINS - 1);

  typedef enum logic [1:0] {IDLE, RD, CMP, WR} state_e;

  state_e      state_q;
  logic [15:0] data_q;
  logic        eop_q;
  logic [9:0]  idx_q;
  logic [9:0]  bin_idx_q;
  logic        in_frame_q;
  logic        bank_sel_q;
  logic        in_ready_q;
  logic        cs_q;
  logic        wr_q;
  logic [9:0]  addr_q;
  logic [15:0] wdata_q;
  logic        frame_done_q;
  logic [15:0] frame_count_q;
  logic        frame_err_q;

  logic [9:0]  next_bin_d;
  logic [9:0]  idx_d;
  logic        drop_d;
  logic [15:0] scaled_d;
  logic [15:0] decayed_d;
  logic [15:0] height_d;
  logic [15:0] unused_rd_hi;

  function automatic logic [15:0] sat_scale(input logic [15:0] mag);
    logic [15:0] s;
    s = mag >> MAG_SHIFT;
    return (s > 16'(MAX_HEIGHT)) ? 16'(MAX_HEIGHT) : s;
  endfunction

  function automatic logic [15:0] peak_decay(input logic [15:0] old);
    return (old >= 16'(DECAY)) ? old - 16'(DECAY) : 16'd0;
  endfunction

  // A non-sop sample needs an open frame and must still land inside the bank.
  always_comb begin
    next_bin_d = bin_idx_q + 10'd1;
    idx_d      = bus.in_sop ? 10'd0 : next_bin_d;
    drop_d     = !bus.in_sop && (!in_frame_q || (next_bin_d > LAST_IDX));
    scaled_d   = sat_scale(data_q);
    decayed_d  = peak_decay(bus.ram_readdata[15:0]);
    height_d   = (scaled_d > decayed_d) ? scaled_d : decayed_d;
  end

  assign unused_rd_hi = bus.ram_readdata[31:16];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      in_ready_q    <= 1'b0;
      cs_q          <= 1'b0;
      wr_q          <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      bank_sel_q    <= 1'b0;
      frame_done_q  <= 1'b0;
      frame_count_q <= '0;
      frame_err_q   <= 1'b0;
      bin_idx_q     <= '0;
      in_frame_q    <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      unique case (state_q)
        // IDLE: accept one sample; dropped samples leave the FSM here
        IDLE: begin
          in_ready_q <= 1'b1;
          cs_q       <= 1'b0;
          wr_q       <= 1'b0;
          if (bus.in_valid && in_ready_q) begin
            if (drop_d) begin
              frame_err_q <= 1'b1;
            end else begin
              if (bus.in_sop && in_frame_q) frame_err_q <= 1'b1;
              data_q     <= bus.in_data;
              eop_q      <= bus.in_eop;
              idx_q      <= idx_d;
              bin_idx_q  <= idx_d;
              in_frame_q <= 1'b1;
              in_ready_q <= 1'b0;
              cs_q       <= 1'b1;
              addr_q     <= {bank_sel_q, idx_d[8:0]};
              state_q    <= RD;
            end
          end
        end
        // RD: front-bank read address is on the bus this cycle
        RD: begin
          cs_q    <= 1'b0;
          state_q <= CMP;
        end
        // CMP: previous height is on ram_readdata; form the new height
        CMP: begin
          cs_q    <= 1'b1;
          wr_q    <= 1'b1;
          addr_q  <= {~bank_sel_q, idx_q[8:0]};
          wdata_q <= height_d;
          state_q <= WR;
        end
        // WR: back-bank write strobe; close the frame on eop
        WR: begin
          cs_q       <= 1'b0;
          wr_q       <= 1'b0;
          in_ready_q <= 1'b1;
          state_q    <= IDLE;
          if (eop_q) begin
            in_frame_q <= 1'b0;
            if (idx_q == LAST_IDX) begin
              bank_sel_q    <= ~bank_sel_q;
              frame_done_q  <= 1'b1;
              frame_count_q <= frame_count_q + 16'd1;
            end else begin
              frame_err_q <= 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.in_ready       = in_ready_q;
  assign bus.ram_address    = addr_q;
  assign bus.ram_byteenable = 4'b1111;
  assign bus.ram_chipselect = cs_q;
  assign bus.ram_write      = wr_q;
  assign bus.ram_writedata  = {16'h0000, wdata_q};
  assign bus.ram_clken      = 1'b1;
  assign bus.bank_sel       = bank_sel_q;
  assign bus.frame_done     = frame_done_q;
  assign bus.frame_count    = frame_count_q;
  assign bus.frame_err      = frame_err_q;

endmodule

// File: tb/tb_fft_bar_ram_writer.sv
// Bench for the bar RAM writer: behavioural 1024x32 RAM, a reference model that predicts
// every RAM write into a scoreboard queue, and a bus monitor that pops and compares.
module tb_fft_bar_ram_writer;
  localparam int NB = 512;

  typedef struct packed {
    logic [9:0]  a;
    logic [31:0] d;
  } wr_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  fft_bar_ram_writer_if bus();

  fft_bar_ram_writer #(.NUM_BINS(NB), .MAG_SHIFT(4), .MAX_HEIGHT(479), .DECAY(2)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  logic [31:0] mem [1024] = '{default: '0};
  logic [31:0] rd_q = '0;
  always @(posedge clk) begin
    if (bus.ram_chipselect === 1'b1 && bus.ram_write === 1'b1) mem[bus.ram_address] <= bus.ram_writedata;
    else if (bus.ram_chipselect === 1'b1) rd_q <= mem[bus.ram_address];
  end
  assign bus.ram_readdata = rd_q;

  int checks = 0;
  int failures = 0;
  int wr_cnt = 0;
  int cs_cnt = 0;
  int done_cnt = 0;
  wr_t sb[$];
  logic [31:0] exp_mem [1024] = '{default: '0};
  int m_bank = 0;
  int m_in_frame = 0;
  int m_bin = 0;
  int m_count = 0;
  int m_err = 0;

  task automatic monitor();
    logic prev_done;
    logic [9:0] last_rd;
    wr_t e;
    prev_done = 1'b0;
    last_rd = '0;
    forever begin
      @(negedge clk);
      if (bus.ram_chipselect === 1'b1) begin
        cs_cnt++;
        checks++;
        if (bus.ram_byteenable !== 4'hF || bus.ram_clken !== 1'b1) begin
          failures++; $display("FAIL const_outs be=%h clken=%b required be=f clken=1", bus.ram_byteenable, bus.ram_clken);
        end
        if (bus.ram_write === 1'b1) begin
          wr_cnt++;
          checks++;
          if (bus.ram_address[9] !== ~bus.bank_sel) begin
            failures++; $display("FAIL wr_bank addr=%0d bank_sel=%b required back bank", bus.ram_address, bus.bank_sel);
          end
          checks++;
          if ((bus.ram_address ^ last_rd) !== 10'h200) begin
            failures++; $display("FAIL rd_wr_offset wr=%0d rd=%0d required differ by 512", bus.ram_address, last_rd);
          end
          checks++;
          if (sb.size() == 0) begin
            failures++; $display("FAIL unexpected_write addr=%0d data=%h required none", bus.ram_address, bus.ram_writedata);
          end else begin
            e = sb.pop_front();
            if (bus.ram_address !== e.a || bus.ram_writedata !== e.d) begin
              failures++; $display("FAIL write addr=%0d data=%h required addr=%0d data=%h", bus.ram_address, bus.ram_writedata, e.a, e.d);
            end
          end
        end else begin
          last_rd = bus.ram_address;
          checks++;
          if (bus.ram_address[9] !== bus.bank_sel) begin
            failures++; $display("FAIL rd_bank addr=%0d bank_sel=%b required front bank", bus.ram_address, bus.bank_sel);
          end
        end
      end
      if (bus.frame_done === 1'b1) begin
        done_cnt++;
        checks++;
        if (prev_done) begin
          failures++; $display("FAIL done_width frame_done high 2 cycles required 1");
        end
      end
      prev_done = (bus.frame_done === 1'b1);
    end
  endtask

  // Reference model predicts the write, then the sample is handed over on the stream.
  task automatic send(input logic [15:0] d, input logic s, input logic e, output int waited);
    int idx;
    int ok;
    logic [15:0] sc, dc, old, h;
    wr_t w;
    ok = 1;
    idx = 0;
    if (s) begin
      if (m_in_frame != 0) m_err = 1;
      m_in_frame = 1;
    end else if (m_in_frame == 0 || m_bin + 1 > NB - 1) begin
      m_err = 1;
      ok = 0;
    end else begin
      idx = m_bin + 1;
    end
    if (ok != 0) begin
      sc = d >> 4;
      if (sc > 16'd479) sc = 16'd479;
      old = exp_mem[m_bank * 512 + idx][15:0];
      dc = (old >= 16'd2) ? old - 16'd2 : 16'd0;
      h = (sc > dc) ? sc : dc;
      exp_mem[(1 - m_bank) * 512 + idx] = {16'h0000, h};
      w.a = 10'((1 - m_bank) * 512 + idx);
      w.d = {16'h0000, h};
      sb.push_back(w);
      m_bin = idx;
      if (e) begin
        m_in_frame = 0;
        if (idx == NB - 1) begin
          m_bank = 1 - m_bank;
          m_count++;
        end else begin
          m_err = 1;
        end
      end
    end
    bus.in_valid = 1'b1;
    bus.in_data = d;
    bus.in_sop = s;
    bus.in_eop = e;
    waited = 0;
    while (bus.in_ready !== 1'b1 && waited < 64) begin
      @(negedge clk);
      waited++;
    end
    checks++;
    if (waited >= 64) begin
      failures++; $display("FAIL send_timeout in_ready=%b required 1 within 64 cycles", bus.in_ready);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    bus.in_valid = 1'b0;
    bus.in_sop = 1'b0;
    bus.in_eop = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic run_frame(input logic [15:0] base, input int sp_bin, input logic [15:0] sp_data, input bit rnd);
    int w;
    logic [15:0] d;
    for (int i = 0; i < NB; i++) begin
      d = rnd ? 16'($urandom) : ((i == sp_bin) ? sp_data : base);
      send(d, i == 0, i == NB - 1, w);
    end
    idle(8);
  endtask

  task automatic check_frame_state(input string tag);
    checks++;
    if (bus.bank_sel !== 1'(m_bank)) begin
      failures++; $display("FAIL %s bank_sel=%b required %0d", tag, bus.bank_sel, m_bank);
    end
    checks++;
    if (bus.frame_count !== 16'(m_count)) begin
      failures++; $display("FAIL %s frame_count=%0d required %0d", tag, bus.frame_count, m_count);
    end
    checks++;
    if (bus.frame_err !== 1'(m_err)) begin
      failures++; $display("FAIL %s frame_err=%b required %0d", tag, bus.frame_err, m_err);
    end
  endtask

  task automatic check_bank(input string tag, input int bank, input logic [31:0] val);
    int bad;
    bad = 0;
    for (int i = 0; i < NB; i++) if (mem[bank * 512 + i] !== val) bad++;
    checks++;
    if (bad != 0) begin
      failures++; $display("FAIL %s bank%0d words_wrong=%0d required 0 (value %h)", tag, bank, bad, val);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle(3);
    checks++;
    if ({bus.in_ready, bus.ram_chipselect, bus.ram_write, bus.bank_sel, bus.frame_done, bus.frame_err} !== 6'b0) begin
      failures++; $display("FAIL reset_ctrl rdy=%b cs=%b wr=%b bank=%b done=%b err=%b required all 0",
        bus.in_ready, bus.ram_chipselect, bus.ram_write, bus.bank_sel, bus.frame_done, bus.frame_err);
    end
    checks++;
    if (bus.ram_address !== 10'd0 || bus.ram_writedata !== 32'd0 || bus.frame_count !== 16'd0) begin
      failures++; $display("FAIL reset_data addr=%0d wdata=%h count=%0d required 0", bus.ram_address, bus.ram_writedata, bus.frame_count);
    end
    checks++;
    if (bus.ram_byteenable !== 4'hF || bus.ram_clken !== 1'b1) begin
      failures++; $display("FAIL reset_const be=%h clken=%b required f 1", bus.ram_byteenable, bus.ram_clken);
    end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b1) begin
      failures++; $display("FAIL ready_after_reset in_ready=%b required 1", bus.in_ready);
    end
  endtask

  task automatic test_frames();
    int d0;
    d0 = done_cnt;
    run_frame(16'h0100, -1, 16'h0, 1'b0);
    check_frame_state("frame1");
    check_bank("frame1", 1, 32'd16);
    checks++;
    if (done_cnt - d0 != 1 || bus.frame_count !== 16'd1 || bus.bank_sel !== 1'b1) begin
      failures++; $display("FAIL frame1_swap pulses=%0d count=%0d bank=%b required 1 1 1", done_cnt - d0, bus.frame_count, bus.bank_sel);
    end
    run_frame(16'h0000, -1, 16'h0, 1'b0);
    check_frame_state("frame2");
    check_bank("frame2", 0, 32'd14);
    repeat (8) run_frame(16'h0000, -1, 16'h0, 1'b0);
    check_frame_state("decay");
    check_bank("decay", 0, 32'd0);
    check_bank("decay", 1, 32'd0);
    checks++;
    if (done_cnt - d0 != 10) begin
      failures++; $display("FAIL done_pulses got=%0d required 10", done_cnt - d0);
    end
  endtask

  task automatic test_saturation();
    run_frame(16'h0000, 7, 16'hFFFF, 1'b0);
    checks++;
    if (mem[512 + 7] !== 32'h0000_01DF) begin
      failures++; $display("FAIL sat_ffff word=%h required 000001df", mem[512 + 7]);
    end
    run_frame(16'h0000, 7, 16'h1DF0, 1'b0);
    checks++;
    if (mem[7] !== 32'h0000_01DF) begin
      failures++; $display("FAIL sat_1df0 word=%h required 000001df", mem[7]);
    end
    check_frame_state("saturation");
  endtask

  task automatic test_back_to_back();
    int w;
    for (int i = 0; i < NB; i++) begin
      send(16'($urandom), i == 0, i == NB - 1, w);
      if (i < 5) begin
        checks++;
        if (w != ((i == 0) ? 0 : 3)) begin
          failures++; $display("FAIL ready_pattern sample=%0d idle_cycles=%0d required %0d", i, w, (i == 0) ? 0 : 3);
        end
      end
    end
    idle(8);
    check_frame_state("back_to_back");
  endtask

  task automatic test_short_frame_and_orphan();
    int w, d0, c0;
    d0 = done_cnt;
    for (int i = 0; i <= 100; i++) send(16'h0400, i == 0, i == 100, w);
    idle(8);
    check_frame_state("short_frame");
    checks++;
    if (done_cnt != d0) begin
      failures++; $display("FAIL short_no_swap pulses=%0d required 0", done_cnt - d0);
    end
    c0 = cs_cnt;
    send(16'h0500, 1'b0, 1'b0, w);
    checks++;
    if (bus.in_ready !== 1'b1) begin
      failures++; $display("FAIL orphan_ready in_ready=%b required 1", bus.in_ready);
    end
    idle(6);
    checks++;
    if (cs_cnt != c0) begin
      failures++; $display("FAIL orphan_cs chipselect_cycles=%0d required 0", cs_cnt - c0);
    end
    run_frame(16'h0300, -1, 16'h0, 1'b0);
    check_frame_state("err_sticky");
  endtask

  task automatic test_reset_mid();
    int w, wc;
    for (int i = 0; i < 5; i++) send(16'($urandom), i == 0, 1'b0, w);
    send(16'h0800, 1'b0, 1'b0, w);
    wc = wr_cnt;
    @(negedge clk);
    reset = 1'b1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.ram_chipselect, bus.ram_write, bus.in_ready, bus.bank_sel, bus.frame_done, bus.frame_err} !== 6'b0 ||
        bus.frame_count !== 16'd0 || bus.ram_address !== 10'd0) begin
      failures++; $display("FAIL mid_reset cs=%b wr=%b rdy=%b bank=%b err=%b count=%0d addr=%0d required all 0",
        bus.ram_chipselect, bus.ram_write, bus.in_ready, bus.bank_sel, bus.frame_err, bus.frame_count, bus.ram_address);
    end
    reset = 1'b0;
    idle(4);
    checks++;
    if (wr_cnt != wc || sb.size() != 1) begin
      failures++; $display("FAIL mid_reset_write writes=%0d pending=%0d required 0 1", wr_cnt - wc, sb.size());
    end
    sb.delete();
    m_bank = 0; m_in_frame = 0; m_bin = 0; m_count = 0; m_err = 0;
    run_frame(16'h0200, -1, 16'h0, 1'b0);
    check_frame_state("after_reset");
  endtask

  task automatic test_overrun();
    int w, c0;
    for (int i = 0; i < NB; i++) send(16'h0100, i == 0, 1'b0, w);
    idle(6);
    c0 = cs_cnt;
    send(16'h0100, 1'b0, 1'b1, w);
    idle(6);
    checks++;
    if (cs_cnt != c0 || bus.frame_err !== 1'b1) begin
      failures++; $display("FAIL overrun cs_cycles=%0d err=%b required 0 1", cs_cnt - c0, bus.frame_err);
    end
    check_frame_state("overrun");
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.in_sop = 1'b0;
    bus.in_eop = 1'b0;
    fork
      monitor();
    join_none
    test_reset();
    test_frames();
    test_saturation();
    test_back_to_back();
    test_short_frame_and_orphan();
    test_reset_mid();
    test_overrun();
    checks++;
    if (sb.size() != 0) begin
      failures++; $display("FAIL scoreboard_drain pending=%0d required 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fft_bar_ram_writer.md
Name: fft_bar_ram_writer

Overview:
- Stage directly upstream of the 1024x32 single-port VGA bar RAM; drives that RAM's Avalon-MM slave port as its only master.
- Consumes a streamed frame of FFT magnitude bins and applies saturation and per-bin peak-hold decay.
- Ping-pong buffering: reads the previous height of each bin from the front bank and writes the new height into the back bank.
- Swaps banks at each complete frame, so the VGA reader never sees a half-written frame.

Parameters:
- NUM_BINS, 512: bins per frame; one bank = NUM_BINS words; bank b occupies addresses b*512 .. b*512+NUM_BINS-1.
- MAG_SHIFT, 4: right shift applied to in_data before saturation.
- MAX_HEIGHT, 479: saturation ceiling for bar height, in pixels.
- DECAY, 2: pixels subtracted per frame from the previous height during peak-hold.

Ports:
- clk, in, 1: system clock; the only clock.
- reset, in, 1: synchronous, active-high.
- in_valid, in, 1: stream sample valid.
- in_ready, out, 1: stream ready; a sample transfers on in_valid & in_ready.
- in_data, in, 16: unsigned FFT magnitude.
- in_sop, in, 1: first bin of a frame.
- in_eop, in, 1: last bin of a frame.
- ram_address, out, 10: RAM word address.
- ram_byteenable, out, 4: always 4'b1111.
- ram_chipselect, out, 1: RAM select.
- ram_write, out, 1: write strobe (effective write = chipselect & write).
- ram_writedata, out, 32: {16'h0, height[15:0]}.
- ram_readdata, in, 32: RAM read data; valid the cycle after the address is presented; only [15:0] is used.
- ram_clken, out, 1: constant 1.
- bank_sel, out, 1: front (displayed) bank; the VGA reader adds bank_sel*512.
- frame_done, out, 1: one-cycle pulse when a bank swap occurs.
- frame_count, out, 16: count of completed frames; wraps.
- frame_err, out, 1: sticky error flag; cleared only by reset.

Behaviour:
- Reset (synchronous, active-high): all outputs return to 0 on the next clk edge, except ram_byteenable (4'b1111) and ram_clken (1). bin_idx=0, in_frame=0, state=IDLE. A reset mid-sample aborts that sample: no write is issued once reset is seen, and there is no partial swap.
- FSM states: IDLE, RD, CMP, WR.
- IDLE: in_ready=1, chipselect=0. On transfer, latch in_data, sop, eop and target idx, then go to RD.
- RD: in_ready=0, chipselect=1, write=0, address = bank_sel*512 + idx. Go to CMP.
- CMP: chipselect=0.
  - scaled = min(in_data >> MAG_SHIFT, MAX_HEIGHT).
  - decayed = (old >= DECAY) ? old-DECAY : 0, where old = ram_readdata[15:0].
  - height = max(scaled, decayed).
  - Go to WR.
- WR: chipselect=1, write=1, address = (~bank_sel)*512 + idx, writedata = height. Return to IDLE.
- Throughput: one sample per 4 clocks. Latency from accept to write strobe: 3 clocks.
- Index rules:
  - A sample with in_sop=1 sets idx=0 and in_frame=1, even if a frame is in progress. An aborted frame sets frame_err and does not swap.
  - A sample with in_sop=0 uses idx = bin_idx+1.
  - A sample with in_frame=0 and no sop is dropped: it is accepted (in_ready=1), FSM stays in IDLE, no RAM access, frame_err=1.
  - idx > NUM_BINS-1 is dropped the same way, with frame_err=1.
- Frame end: when the WR of an eop sample completes:
  - If idx == NUM_BINS-1: toggle bank_sel, pulse frame_done for the cycle after WR, increment frame_count (wraps 16'hFFFF -> 0), clear in_frame.
  - Otherwise (short frame): no swap, frame_err=1, clear in_frame.
- Sample with both sop and eop set: treated as a one-bin frame. It swaps only if NUM_BINS == 1; otherwise it sets frame_err.
- The front bank is never written; the back bank is never read.
- Back bank contents after a swap are stale by design; they are overwritten by the next frame.

Test Plan:
- Reset, then one full frame of 512 samples with in_data=16'h0100 (scaled 16), RAM preloaded to 0 → addresses 512..1023 hold 16, bank_sel 0→1, frame_done high exactly 1 cycle, frame_count=1, frame_err=0.
- Second frame, all in_data=0 → bank 0 words = 14 (16-2), bank_sel→0. Continue with zero frames → heights step 14,12,…,2,0 and stay at 0 with no underflow.
- Saturation: in_data=16'hFFFF at bin 7 → written word = 479 (0x1DF) with upper 16 bits zero. Same check with in_data=16'h1DF0 → 479.
- Back-to-back in_valid held high → in_ready pattern 1,0,0,0 repeating; RD/WR addresses differ by exactly 512; read data is sampled the cycle after the RD address.
- Short frame with eop at idx 100 → no bank swap, frame_err=1 and stays 1. Orphan sample with no sop → no chipselect asserted.
- Reset asserted during CMP of bin 5 → no write strobe at WR, outputs return to reset values next cycle. A following full frame completes normally with frame_count=1.
